// File: rtl/io_pkg.sv
// io_pkg: shared state encoding and IO address map for the IO bus.
// Used by io_master, its bench and firmware-facing headers.
package io_pkg;

  localparam int unsigned IO_DW = 16;
  localparam int unsigned IO_AW = 13;
  localparam int unsigned IO_LW = 8;

  localparam int unsigned GPI_ADDR = 0;
  localparam int unsigned GPO_ADDR = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_ADDR,
    S_RD_CAPT,
    S_RD_OUT
  } state_e;

endpackage

// File: rtl/io_master_if.sv
// io_master_if: host command/data streams plus the IO bus pins.
// master = io_master view, slave = host/responder view.
interface io_master_if #(
  parameter int DW = 16,
  parameter int AW = 13,
  parameter int LW = 8
) ();

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic          cmd_inc;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;

  logic          wd_valid;
  logic          wd_ready;
  logic [DW-1:0] wd_data;

  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last;

  logic          busy;

  logic [AW-1:0] bus_addr;
  logic          bus_we;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;

  modport master (
    input  cmd_valid, cmd_we, cmd_inc,
    input  cmd_addr, cmd_len,
    output cmd_ready,
    input  wd_valid, wd_data,
    output wd_ready,
    output rd_valid, rd_data, rd_last,
    input  rd_ready,
    output busy,
    output bus_addr, bus_we, bus_wdata,
    input  bus_rdata
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_inc,
    output cmd_addr, cmd_len,
    input  cmd_ready,
    output wd_valid, wd_data,
    input  wd_ready,
    input  rd_valid, rd_data, rd_last,
    output rd_ready,
    input  busy,
    input  bus_addr, bus_we, bus_wdata,
    output bus_rdata
  );

endinterface

// File: rtl/io_master_addr_gen.sv
// io_master_addr_gen: burst address, remaining-word count, last flag.
// Address wraps modulo 2^AW when incrementing.
module io_master_addr_gen #(
  parameter int AW = 13,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          adv,
  input  logic [AW-1:0] ld_addr,
  input  logic [LW-1:0] ld_len,
  input  logic          ld_inc,
  output logic [AW-1:0] addr,
  output logic          last
);

  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          inc_q, inc_d;

  // load a new burst or step to the next word
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    inc_d  = inc_q;
    if (load) begin
      addr_d = ld_addr;
      cnt_d  = ld_len;
      inc_d  = ld_inc;
    end else if (adv) begin
      if (inc_q) addr_d = addr_q + AW'(1);
      cnt_d = cnt_q - LW'(1);
    end
  end

  // burst position registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      cnt_q  <= '0;
      inc_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      inc_q  <= inc_d;
    end
  end

  assign addr = addr_q;
  assign last = (cnt_q == '0);

endmodule

// File: rtl/io_master.sv
// io_master: burst initiator for the IO bus, hides 1-cycle read latency.
// Optional abort input enabled by `define IO_MASTER_ABORT_EN.
module io_master
  import io_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 13,
  parameter int LW = 8
) (
  input  logic clk,
  input  logic rst,
`ifdef IO_MASTER_ABORT_EN
  input  logic abort,
`endif
  io_master_if.master io
);

  state_e        state_q, state_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_last_q, rd_last_d;
  logic          ld, adv, last, ab;
  logic [AW-1:0] addr;

`ifdef IO_MASTER_ABORT_EN
  assign ab = abort;
`else
  assign ab = 1'b0;
`endif

  io_master_addr_gen #(
    .AW (AW),
    .LW (LW)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (ld),
    .adv     (adv),
    .ld_addr (io.cmd_addr),
    .ld_len  (io.cmd_len),
    .ld_inc  (io.cmd_inc),
    .addr    (addr),
    .last    (last)
  );

  // next state, bus strobes and read-word staging
  always_comb begin
    state_d      = state_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = rd_valid_q;
    rd_last_d    = rd_last_q;
    ld           = 1'b0;
    adv          = 1'b0;
    io.cmd_ready = 1'b0;
    io.wd_ready  = 1'b0;
    io.bus_we    = 1'b0;
    io.bus_wdata = '0;
    unique case (state_q)
      S_IDLE: begin
        io.cmd_ready = 1'b1;
        if (io.cmd_valid) begin
          ld      = 1'b1;
          state_d = io.cmd_we ? S_WR : S_RD_ADDR;
        end
      end
      S_WR: begin
        io.wd_ready  = 1'b1;
        io.bus_we    = io.wd_valid;
        io.bus_wdata = io.wd_data;
        if (io.wd_valid) begin
          if (last) state_d = S_IDLE;
          else      adv     = 1'b1;
        end
        if (ab) state_d = S_IDLE;
      end
      S_RD_ADDR: begin
        state_d = ab ? S_IDLE : S_RD_CAPT;
      end
      S_RD_CAPT: begin
        rd_data_d  = io.bus_rdata;
        rd_valid_d = 1'b1;
        rd_last_d  = last | ab;
        state_d    = S_RD_OUT;
      end
      S_RD_OUT: begin
        if (io.rd_ready) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          if (rd_last_q | ab) begin
            state_d = S_IDLE;
          end else begin
            adv     = 1'b1;
            state_d = S_RD_ADDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and read output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  assign io.bus_addr = addr;
  assign io.rd_data  = rd_data_q;
  assign io.rd_valid = rd_valid_q;
  assign io.rd_last  = rd_last_q | (ab & (state_q == S_RD_OUT));
  assign io.busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_io_master.sv
// tb_io_master: directed and random bursts against a memory model.
// Responder: GPI at 0, GPO at 1, storage elsewhere, 1-cycle read.
`timescale 1ns/1ps
module tb_io_master;
  import io_pkg::*;

  localparam int DW = 16;
  localparam int AW = 13;
  localparam int LW = 8;
  localparam int NW = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  io_master_if #(.DW(DW), .AW(AW), .LW(LW)) bus_if ();

`ifdef IO_MASTER_ABORT_EN
  logic abort = 1'b0;
`endif

  io_master #(.DW(DW), .AW(AW), .LW(LW)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef IO_MASTER_ABORT_EN
    .abort (abort),
`endif
    .io    (bus_if)
  );

  function automatic logic [DW-1:0] seed_val(input logic [AW-1:0] a);
    return DW'({a, 3'b101}) ^ 16'hC3A5;
  endfunction

  logic [DW-1:0] mem [NW];
  bit            wmask [NW];
  logic [DW-1:0] gpo = '0;
  logic [DW-1:0] dout = '0;
  logic [DW-1:0] gpio_in = '0;

  assign bus_if.bus_rdata = dout;

  always @(posedge clk) begin
    if (bus_if.bus_we) begin
      mem[bus_if.bus_addr]   <= bus_if.bus_wdata;
      wmask[bus_if.bus_addr] <= 1'b1;
      if (bus_if.bus_addr == AW'(GPO_ADDR)) gpo <= bus_if.bus_wdata;
    end else if (bus_if.bus_addr == AW'(GPI_ADDR)) begin
      dout <= gpio_in;
    end else begin
      dout <= wmask[bus_if.bus_addr] ? mem[bus_if.bus_addr]
                                     : seed_val(bus_if.bus_addr);
    end
  end

  logic [DW-1:0] model [NW];
  bit            mwr [NW];

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == AW'(GPI_ADDR)) return gpio_in;
    return mwr[a] ? model[a] : seed_val(a);
  endfunction

  task automatic issue(input logic we, input logic inc,
                       input logic [AW-1:0] a, input logic [LW-1:0] len);
    @(negedge clk);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_we    = we;
    bus_if.cmd_inc   = inc;
    bus_if.cmd_addr  = a;
    bus_if.cmd_len   = len;
    @(posedge clk);
    #1;
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus_if.cmd_ready !== 1'b1 || bus_if.busy !== 1'b0 ||
        bus_if.wd_ready !== 1'b0 || bus_if.bus_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: rdy=%b busy=%b wdr=%b we=%b want 1 0 0 0",
               bus_if.cmd_ready, bus_if.busy, bus_if.wd_ready,
               bus_if.bus_we);
    end
    checks++;
    if (bus_if.rd_valid !== 1'b0 || bus_if.rd_last !== 1'b0 ||
        bus_if.rd_data !== '0 || bus_if.bus_addr !== '0 ||
        bus_if.bus_wdata !== '0) begin
      errors++;
      $display("FAIL reset_dat: rv=%b rl=%b rd=%h a=%h wd=%h want zeros",
               bus_if.rd_valid, bus_if.rd_last, bus_if.rd_data,
               bus_if.bus_addr, bus_if.bus_wdata);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single_write();
    @(negedge clk);
    #1;
    checks++;
    if (bus_if.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL sw_ready: got %b want 1", bus_if.cmd_ready);
    end
    issue(1'b1, 1'b1, AW'(GPO_ADDR), '0);
    @(negedge clk);
    bus_if.wd_valid = 1'b1;
    bus_if.wd_data  = 16'hA5C3;
    #1;
    checks++;
    if (bus_if.bus_we !== 1'b1 || bus_if.bus_addr !== AW'(1) ||
        bus_if.bus_wdata !== 16'hA5C3 || bus_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL sw_bus: we=%b a=%h d=%h busy=%b want 1 0001 a5c3 1",
               bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata,
               bus_if.busy);
    end
    model[AW'(GPO_ADDR)] = 16'hA5C3;
    mwr[AW'(GPO_ADDR)]   = 1'b1;
    @(negedge clk);
    bus_if.wd_valid = 1'b0;
    #1;
    checks++;
    if (gpo !== 16'hA5C3 || bus_if.busy !== 1'b0 ||
        bus_if.bus_we !== 1'b0) begin
      errors++;
      $display("FAIL sw_after: gpo=%h busy=%b we=%b want a5c3 0 0",
               gpo, bus_if.busy, bus_if.bus_we);
    end
  endtask

  task automatic test_single_read();
    int n;
    int first;
    gpio_in = 16'h1234;
    bus_if.rd_ready = 1'b1;
    repeat (2) @(negedge clk);
    issue(1'b0, 1'b0, AW'(GPI_ADDR), '0);
    first = 0;
    n = 0;
    while (first == 0 && n < 10) begin
      @(negedge clk);
      n++;
      #1;
      if (bus_if.rd_valid === 1'b1) begin
        first = n;
        checks++;
        if (bus_if.rd_data !== 16'h1234 || bus_if.rd_last !== 1'b1) begin
          errors++;
          $display("FAIL sr_word: d=%h last=%b want 1234 1",
                   bus_if.rd_data, bus_if.rd_last);
        end
      end
    end
    checks++;
    if (first != 3) begin
      errors++;
      $display("FAIL sr_latency: got %0d cycles want 3", first);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL sr_idle: busy=%b rv=%b want 0 0",
               bus_if.busy, bus_if.rd_valid);
    end
  endtask

  task automatic test_fixed_backpressure();
    int k;
    int hold;
    int cyc;
    gpio_in = DW'($urandom);
    repeat (2) @(negedge clk);
    issue(1'b0, 1'b0, AW'(GPI_ADDR), LW'(3));
    k = 0;
    hold = 0;
    cyc = 0;
    while (k <= 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      bus_if.rd_ready = !(bus_if.rd_valid === 1'b1 && k == 1 && hold < 5);
      #1;
      checks++;
      if (bus_if.bus_we !== 1'b0) begin
        errors++;
        $display("FAIL fb_we: got %b want 0", bus_if.bus_we);
      end
      if (bus_if.rd_valid === 1'b1) begin
        checks++;
        if (bus_if.rd_data !== gpio_in || bus_if.rd_last !== (k == 3)) begin
          errors++;
          $display("FAIL fb_word%0d: d=%h last=%b want %h %b", k,
                   bus_if.rd_data, bus_if.rd_last, gpio_in, (k == 3));
        end
        if (bus_if.rd_ready) k++;
        else                 hold++;
      end
    end
    checks++;
    if (k != 4 || hold != 5) begin
      errors++;
      $display("FAIL fb_count: words=%0d hold=%0d want 4 5", k, hold);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL fb_idle: busy=%b want 0", bus_if.busy);
    end
  endtask

  task automatic test_wrap_write();
    int k;
    int cyc;
    logic [AW-1:0] ea;
    logic [DW-1:0] d;
    issue(1'b1, 1'b1, AW'(13'h1FFE), LW'(2));
    k = 0;
    cyc = 0;
    while (k <= 2 && cyc < 50) begin
      @(negedge clk);
      d = DW'($urandom);
      bus_if.wd_valid = (cyc % 2 == 0);
      bus_if.wd_data  = d;
      #1;
      ea = AW'(13'h1FFE + k);
      checks++;
      if (bus_if.bus_we !== bus_if.wd_valid) begin
        errors++;
        $display("FAIL ww_we: got %b want %b", bus_if.bus_we,
                 bus_if.wd_valid);
      end
      if (bus_if.wd_valid) begin
        checks++;
        if (bus_if.bus_addr !== ea || bus_if.bus_wdata !== d) begin
          errors++;
          $display("FAIL ww_word%0d: a=%h d=%h want %h %h", k,
                   bus_if.bus_addr, bus_if.bus_wdata, ea, d);
        end
        model[ea] = d;
        mwr[ea]   = 1'b1;
        k++;
      end
      cyc++;
    end
    @(negedge clk);
    bus_if.wd_valid = 1'b0;
    #1;
    checks++;
    if (k != 3 || bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL ww_end: words=%0d busy=%b want 3 0", k, bus_if.busy);
    end
  endtask

  task automatic test_reset_mid_read();
    int k;
    int cyc;
    bit done;
    logic [AW-1:0] a0;
    a0 = AW'($urandom_range(2, NW - 8));
    issue(1'b0, 1'b1, a0, LW'(3));
    k = 0;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus_if.rd_valid === 1'b1 && k == 1) begin
        bus_if.rd_ready = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (bus_if.rd_valid !== 1'b0 || bus_if.busy !== 1'b0 ||
            bus_if.cmd_ready !== 1'b1 || bus_if.rd_last !== 1'b0) begin
          errors++;
          $display("FAIL rm_reset: rv=%b busy=%b rdy=%b rl=%b want 0 0 1 0",
                   bus_if.rd_valid, bus_if.busy, bus_if.cmd_ready,
                   bus_if.rd_last);
        end
        done = 1'b1;
      end else begin
        bus_if.rd_ready = 1'b1;
        #1;
        if (bus_if.rd_valid === 1'b1) begin
          checks++;
          if (bus_if.rd_data !== exp_rd(a0)) begin
            errors++;
            $display("FAIL rm_word0: d=%h want %h", bus_if.rd_data,
                     exp_rd(a0));
          end
          k++;
        end
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL rm_timeout: word 2 never offered");
    end
    @(negedge clk);
    rst = 1'b1;
    bus_if.rd_ready = 1'b1;
    issue(1'b0, 1'b0, AW'(GPO_ADDR), '0);
    done = 1'b0;
    cyc = 0;
    while (!done && cyc < 10) begin
      @(negedge clk);
      cyc++;
      #1;
      if (bus_if.rd_valid === 1'b1) begin
        done = 1'b1;
        checks++;
        if (bus_if.rd_data !== exp_rd(AW'(GPO_ADDR)) ||
            bus_if.rd_last !== 1'b1) begin
          errors++;
          $display("FAIL rm_after: d=%h last=%b want %h 1", bus_if.rd_data,
                   bus_if.rd_last, exp_rd(AW'(GPO_ADDR)));
        end
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL rm_after_timeout: no read after reset release");
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int b = 0; b < 24; b++) begin
      logic          we;
      logic          inc;
      logic [AW-1:0] a0;
      logic [AW-1:0] ea;
      logic [LW-1:0] len;
      logic [DW-1:0] d;
      logic          v;
      int            k;
      int            cyc;
      we  = 1'($urandom_range(0, 1));
      inc = 1'($urandom_range(0, 1));
      len = LW'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) a0 = AW'(13'h1FFC + $urandom_range(0, 3));
      else                           a0 = AW'($urandom);
      if (b < 2) begin
        we  = (b == 0);
        inc = 1'b1;
        len = '1;
        a0  = AW'(13'h1F80);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus_if.cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL rnd%0d_ready: got %b want 1", b, bus_if.cmd_ready);
      end
      issue(we, inc, a0, len);
      k = 0;
      cyc = 0;
      while (k <= int'(len) && cyc < 4000) begin
        @(negedge clk);
        cyc++;
        ea = AW'(a0 + (inc ? k : 0));
        if (we) begin
          v = ($urandom_range(0, 3) != 0);
          d = DW'($urandom);
          bus_if.wd_valid = v;
          bus_if.wd_data  = d;
          #1;
          checks++;
          if (bus_if.bus_we !== v || bus_if.wd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rnd%0d_wstrobe: we=%b wdr=%b want %b 1", b,
                     bus_if.bus_we, bus_if.wd_ready, v);
          end
          if (v) begin
            checks++;
            if (bus_if.bus_addr !== ea || bus_if.bus_wdata !== d) begin
              errors++;
              $display("FAIL rnd%0d_w%0d: a=%h d=%h want %h %h", b, k,
                       bus_if.bus_addr, bus_if.bus_wdata, ea, d);
            end
            model[ea] = d;
            mwr[ea]   = 1'b1;
            k++;
          end
        end else begin
          bus_if.rd_ready = ($urandom_range(0, 2) != 0);
          #1;
          checks++;
          if (bus_if.bus_we !== 1'b0) begin
            errors++;
            $display("FAIL rnd%0d_rwe: got %b want 0", b, bus_if.bus_we);
          end
          if (bus_if.rd_valid === 1'b1 && bus_if.rd_ready) begin
            checks++;
            if (bus_if.rd_data !== exp_rd(ea) ||
                bus_if.rd_last !== (k == int'(len))) begin
              errors++;
              $display("FAIL rnd%0d_r%0d: d=%h last=%b want %h %b", b, k,
                       bus_if.rd_data, bus_if.rd_last, exp_rd(ea),
                       (k == int'(len)));
            end
            k++;
          end
        end
      end
      @(negedge clk);
      bus_if.wd_valid = 1'b0;
      bus_if.rd_ready = 1'b0;
      #1;
      checks++;
      if (k != int'(len) + 1 || bus_if.busy !== 1'b0 ||
          bus_if.rd_valid !== 1'b0) begin
        errors++;
        $display("FAIL rnd%0d_end: words=%0d busy=%b rv=%b want %0d 0 0", b,
                 k, bus_if.busy, bus_if.rd_valid, int'(len) + 1);
      end
    end
  endtask

`ifdef IO_MASTER_ABORT_EN
  task automatic test_abort();
    int k;
    int cyc;
    bit done;
    logic [AW-1:0] a0;
    a0 = AW'($urandom_range(2, NW - 8));
    bus_if.rd_ready = 1'b1;
    issue(1'b0, 1'b1, a0, LW'(5));
    k = 0;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus_if.rd_valid === 1'b1 && k == 1) abort = 1'b1;
      #1;
      if (bus_if.rd_valid === 1'b1) begin
        checks++;
        if (bus_if.rd_data !== exp_rd(AW'(a0 + k)) ||
            bus_if.rd_last !== (k == 1)) begin
          errors++;
          $display("FAIL ab_word%0d: d=%h last=%b want %h %b", k,
                   bus_if.rd_data, bus_if.rd_last, exp_rd(AW'(a0 + k)),
                   (k == 1));
        end
        if (k == 1) done = 1'b1;
        k++;
      end
    end
    @(negedge clk);
    abort = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (bus_if.busy !== 1'b0 || bus_if.rd_valid !== 1'b0 || !done) begin
        errors++;
        $display("FAIL ab_idle%0d: busy=%b rv=%b done=%b want 0 0 1", i,
                 bus_if.busy, bus_if.rd_valid, done);
      end
      @(negedge clk);
    end
    bus_if.rd_ready = 1'b0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_we    = 1'b0;
    bus_if.cmd_inc   = 1'b0;
    bus_if.cmd_addr  = '0;
    bus_if.cmd_len   = '0;
    bus_if.wd_valid  = 1'b0;
    bus_if.wd_data   = '0;
    bus_if.rd_ready  = 1'b0;
    test_reset();
    test_single_write();
    test_single_read();
    test_fixed_backpressure();
    test_wrap_write();
    test_reset_mid_read();
    test_random();
`ifdef IO_MASTER_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_master.md
Name: io_master

Overview:
- Bus initiator for the 16-bit memory-mapped IO bus: drives addr/we/din toward IO-space responders and captures their registered read data.
- Takes burst commands from a host-side valid/ready interface, for example a debug bridge or a future DMA.
- Streams write data in and read data out, one bus word at a time, and hides the responders' one-cycle read latency.

Parameters:
- DW, 16, bus data width
- AW, 13, bus address width
- LW, 8, burst length field width; a burst moves cmd_len+1 words

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&ready
- cmd_we  in  1  1 = write burst, 0 = read burst
- cmd_inc  in  1  1 = increment address per word, 0 = fixed address
- cmd_addr  in  AW  start address
- cmd_len  in  LW  word count minus one
- wd_valid  in  1  write data offered
- wd_ready  out  1  write data consumed
- wd_data  in  DW  write data
- rd_valid  out  1  read word available
- rd_ready  in  1  host takes read word
- rd_data  out  DW  read word
- rd_last  out  1  marks final word of a burst
- busy  out  1  burst in progress
- bus_addr  out  AW  to responder addr
- bus_we  out  1  to responder we, high = write
- bus_wdata  out  DW  to responder din
- bus_rdata  in  DW  from responder dout

Behaviour:
- Reset (async, rst low): state IDLE; cmd_ready=1; wd_ready, rd_valid, rd_last, busy, bus_we = 0; bus_addr, bus_wdata, rd_data = 0; counters = 0.
- States: IDLE, WR, RD_ADDR, RD_CAPT, RD_OUT.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch addr, len, inc, we.
  - Next state: WR if we=1, otherwise RD_ADDR.
  - busy=1 from the next cycle.
- WR:
  - wd_ready=1, combinationally.
  - bus_we = wd_valid, bus_wdata = wd_data, bus_addr = current address, all combinational from the registered address.
  - Each cycle with wd_valid: one bus write, the remaining count decrements, and the address advances if inc.
  - After the final word, go to IDLE.
  - wd_valid low leaves bus_we=0 and the state unchanged (no bubble limit).
- RD_ADDR: bus_addr = current address, bus_we=0 for exactly one cycle; go to RD_CAPT.
- RD_CAPT:
  - Register bus_rdata into rd_data; this is the responder's 1-cycle latency.
  - Set rd_valid=1, and rd_last=1 if this is the final word; go to RD_OUT.
- RD_OUT:
  - Hold rd_valid and rd_data until rd_ready.
  - On handshake: clear rd_valid. If words remain, advance the address (if inc), decrement, and go to RD_ADDR. Otherwise go to IDLE.
- Read throughput is one word per 3 cycles at best; this is accepted.
- bus_we is never high outside WR.
- Address increments wrap modulo 2^AW (1FFF -> 0000).
- cmd_len=0 moves exactly one word; cmd_len=2^LW-1 moves 2^LW words.
- A command arriving while busy is not accepted (cmd_ready=0 whenever not IDLE).
- Responders that do not decode an address leave their dout stale. The master captures whatever bus_rdata holds, and this is defined behaviour.
- busy = (state != IDLE).
- Reset mid-burst: immediate return to reset values; a partially delivered burst is lost and no rd_last is issued.

Optional Feature:
- IO_MASTER_ABORT_EN: adds input abort (1 bit).
- When defined:
  - abort high in WR ends the burst after any write handshaking in that same cycle.
  - abort high in RD_ADDR goes to IDLE with no further reads.
  - In RD_CAPT/RD_OUT, the current word completes with rd_last forced to 1, then the state goes to IDLE.
  - abort in IDLE is ignored.
- When undefined: no port, and bursts always run to completion.

Decomposition:
- Shared package io_pkg:
  - state encoding typedef (IDLE..RD_OUT)
  - the IO address map constants already used by the IO block (GPI address 0x0000, GPO address 0x0001), reused by bench and firmware headers
- Sub-module io_master_addr_gen: address register, increment/wrap, remaining-word counter, last flag.
- The FSM stays in io_master.

Test Plan:
- Single write: cmd we=1, addr=0x0001, len=0, wd_data=0xA5C3 -> one cycle with bus_we=1, bus_addr=0x0001, bus_wdata=0xA5C3; GPO of the attached IO block reads 0xA5C3 next cycle; busy falls.
- Single read: gpio_in=0x1234, held ≥2 cycles; cmd we=0, addr=0x0000, len=0 -> rd_valid with rd_data=0x1234, rd_last=1, 3 cycles after acceptance.
- Burst read with fixed address and backpressure: cmd addr=0x0000, inc=0, len=3; rd_ready held low 5 cycles on word 1 -> rd_data stable while waiting; 4 words total; rd_last only on the 4th; bus_we never 1.
- Write burst with wrap: addr=0x1FFE, inc=1, len=2, wd_valid gapped every other cycle -> bus_addr sequence 1FFE, 1FFF, 0000; bus_we high only on valid cycles.
- Reset mid-read: assert rst low during RD_OUT of word 2 of 4 -> rd_valid=0, busy=0, cmd_ready=1 immediately; a new command is accepted after release.
- (IO_MASTER_ABORT_EN) abort during word 2 of a len=5 read -> word 2 delivered with rd_last=1; no further bus reads; IDLE.
